// File: rtl/uart_sched.sv
// Round-robin Wishbone master sharing the lab UART transmitter among N_REQ byte requesters.
// Define UART_SCHED_RX_EN to also drain the UART receiver (continuous polling plus RX reads).
module uart_sched #(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] UART_BASE = 32'h9000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [31:0]        wb_adr_o,
  output logic [3:0]         wb_sel_o,
  output logic [31:0]        wb_dat_o,
  input  logic [31:0]        wb_dat_i,
  input  logic               wb_ack_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, POLL, GAP1, RXRD, WRITE, GAP2} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, grant, pick;
  logic [1:0]    tx_empty;
  logic [7:0]    tx_byte;
  logic          found;
  int            j;

`ifdef UART_SCHED_RX_EN
  logic          rx_full;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          unused_dat;

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign unused_dat = ^{wb_dat_i[23], wb_dat_i[20:17], wb_dat_i[15:0]};
`else
  logic          unused_dat;

  assign rx_data    = 8'h00;
  assign rx_valid   = 1'b0;
  assign unused_dat = ^{wb_dat_i[31:23], wb_dat_i[20:0]};
`endif

  assign wb_adr_o = UART_BASE;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = j[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef UART_SCHED_RX_EN
        state_nxt = POLL;
`else
        if (|req_valid) state_nxt = POLL;
`endif
      end
      POLL: if (wb_ack_i) state_nxt = GAP1;
      GAP1: begin
        state_nxt = IDLE;
        if (tx_empty == 2'b11 && req_valid[grant]) state_nxt = WRITE;
`ifdef UART_SCHED_RX_EN
        // A full receiver wins over TX so the UART never overruns.
        if (rx_full) state_nxt = RXRD;
`endif
      end
      RXRD: begin
`ifdef UART_SCHED_RX_EN
        if (wb_ack_i) state_nxt = GAP2;
`else
        state_nxt = IDLE;
`endif
      end
      WRITE:   if (wb_ack_i) state_nxt = GAP2;
      GAP2:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = 4'b0000;
    wb_dat_o = 32'h0;
    busy     = (state != IDLE);
    case (state)
      POLL: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'b0100;
      end
      RXRD: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'b1000;
      end
      WRITE: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_sel_o = 4'b1000;
        wb_dat_o = {tx_byte, 24'h0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      grant      <= '0;
      tx_empty   <= 2'b00;
      tx_byte    <= 8'h00;
      req_ready  <= '0;
`ifdef UART_SCHED_RX_EN
      rx_full    <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
`endif
    end else begin
      req_ready  <= '0;
`ifdef UART_SCHED_RX_EN
      rx_valid_q <= 1'b0;
`endif
      case (state)
        POLL: if (wb_ack_i) begin
          grant    <= pick;
          tx_empty <= wb_dat_i[22:21];
`ifdef UART_SCHED_RX_EN
          rx_full  <= wb_dat_i[16];
`endif
        end
        GAP1: if (state_nxt == WRITE) tx_byte <= req_data[8*grant +: 8];
`ifdef UART_SCHED_RX_EN
        RXRD: if (wb_ack_i) begin
          rx_data_q  <= wb_dat_i[31:24];
          rx_valid_q <= 1'b1;
        end
`endif
        WRITE: if (wb_ack_i) begin
          req_ready[grant] <= 1'b1;
          rr_ptr           <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sched.sv
// Directed bench for uart_sched: a UART slave model, a transaction-level round-robin model
// and literal expectations for each scenario. Define UART_SCHED_RX_EN to include the RX case.
module tb_uart_sched;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h9000_0000;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } tr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  vld;
  logic [7:0]    byte_of [N];
  int            cnt [N];
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [7:0]    rx_data;
  logic          rx_valid, busy;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0]   wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;

  int   n_cmp = 0, n_fail = 0;
  int   n_writes = 0, n_polls = 0, n_ready = 0, n_rxv = 0;
  tr_t  tr_log [$];
  logic [7:0] wr_log [$];

  int         busy_polls;
  logic       rx_full_m, extra_ack;
  logic [7:0] rx_byte_m;

  assign req_data = {byte_of[3], byte_of[2], byte_of[1], byte_of[0]};

  uart_sched #(.N_REQ(N), .UART_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_data(req_data), .req_ready(req_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // UART slave: ack one cycle after stb, optionally held one extra cycle.
  logic s_stb, s_ack, s_we, ack_n;
  logic [3:0]  s_sel;
  logic [31:0] dat_n;
  always begin
    @(negedge clk);
    s_stb = wb_stb_o; s_ack = wb_ack_i; s_we = wb_we_o; s_sel = wb_sel_o;
    if (s_stb && s_ack && !s_we) begin
      if (s_sel == 4'b0100 && busy_polls > 0) busy_polls--;
      if (s_sel[3]) rx_full_m = 1'b0;
    end
    ack_n = (s_stb && !s_ack) || (s_stb && s_ack && extra_ack);
    dat_n = wb_dat_i;
    if (s_stb && !s_ack && !s_we)
      dat_n = s_sel[3] ? {rx_byte_m, 24'h0}
                       : {rx_byte_m, 1'b0, ((busy_polls > 0) ? 2'b00 : 2'b11), 4'b0, rx_full_m, 16'h0};
    @(posedge clk);
    #1;
    wb_ack_i = ack_n;
    wb_dat_i = dat_n;
  end

  // Requesters hold their byte until the pulse, then reload or drop.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (rst_n && req_ready[i] && vld[i]) begin
        cnt[i]--;
        if (cnt[i] <= 0) vld[i] = 1'b0;
      end
  end

  int         model_rr, g;
  logic       write_ok, rx_pend, exp_rxv;
  logic [N-1:0] exp_ready;
  logic [7:0] exp_rxd;
  tr_t        t;
  always @(negedge clk) begin
    if (!rst_n) begin
      model_rr = 0; write_ok = 1'b0; rx_pend = 1'b0; exp_ready = '0; exp_rxv = 1'b0;
    end else begin
      check_output("adr", wb_adr_o, BASE);
      check_output("cyc_eq_stb", wb_cyc_o, wb_stb_o);
      if (wb_stb_o) check_output("busy_in_cycle", busy, 1'b1);
      check_output("req_ready", req_ready, exp_ready);
      n_ready += $countones(req_ready);
`ifdef UART_SCHED_RX_EN
      check_output("rx_valid", rx_valid, exp_rxv);
      if (exp_rxv) check_output("rx_data", rx_data, exp_rxd);
      if (rx_valid) n_rxv++;
`else
      check_output("rx_tied_off", {rx_valid, rx_data}, 9'h0);
`endif
      exp_ready = '0;
      exp_rxv   = 1'b0;
      if (wb_stb_o && wb_ack_i) begin
        t.we = wb_we_o; t.sel = wb_sel_o; t.dat = wb_we_o ? wb_dat_o : wb_dat_i;
        tr_log.push_back(t);
        if (!wb_we_o) begin
          if (wb_sel_o == 4'b0100) begin
            n_polls++;
`ifdef UART_SCHED_RX_EN
            check_output("poll_while_rx_full", rx_pend, 1'b0);
            rx_pend  = wb_dat_i[16];
            write_ok = (wb_dat_i[22:21] == 2'b11) && !rx_pend;
`else
            write_ok = (wb_dat_i[22:21] == 2'b11);
`endif
          end else begin
`ifdef UART_SCHED_RX_EN
            check_output("rx_read_sel", wb_sel_o, 4'b1000);
            check_output("rx_read_wanted", rx_pend, 1'b1);
            rx_pend  = 1'b0;
            write_ok = 1'b0;
            exp_rxv  = 1'b1;
            exp_rxd  = wb_dat_i[31:24];
`else
            check_output("read_sel", wb_sel_o, 4'b0100);
`endif
          end
        end else begin
          n_writes++;
          check_output("write_sel", wb_sel_o, 4'b1000);
          check_output("write_after_empty_poll", write_ok, 1'b1);
          g = rr_pick(vld, model_rr);
          if (g < 0) check_output("write_has_owner", 1'b0, 1'b1);
          else begin
            check_output("write_data", wb_dat_o, {byte_of[g], 24'h0});
            exp_ready = N'(1) << g;
            model_rr  = (g + 1) % N;
            wr_log.push_back(wb_dat_o[31:24]);
          end
          write_ok = 1'b0;
        end
      end
    end
  end

  task automatic apply_stimulus(input int idx, input logic [7:0] b, input int count);
    byte_of[idx] = b;
    cnt[idx]     = count;
    vld[idx]     = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = '0; busy_polls = 0; rx_full_m = 1'b0; extra_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_outputs",
      {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o, req_ready, rx_valid, rx_data, busy}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_readies(input int target, input string name);
    int k = 0;
    while (n_ready < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_output(name, (n_ready >= target), 1'b1);
    repeat (6) @(negedge clk);
  endtask

  int s_w, s_r, s_p, s_tr, s_wl, lat, w_idx, rx_idx, k;
  logic [7:0] rr_exp [5];

  initial begin
    rst_n = 1'b0; vld = '0; wb_ack_i = 1'b0; wb_dat_i = 32'h0; rx_byte_m = 8'h00;
    for (int i = 0; i < N; i++) begin byte_of[i] = 8'h00; cnt[i] = 0; end
    rr_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();

    $display("[TB] single byte");
    s_w = n_writes; s_tr = tr_log.size();
    @(posedge clk); #1 apply_stimulus(0, 8'h41, 1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!req_ready[0] && lat < 30);
`ifndef UART_SCHED_RX_EN
    check_output("single_latency", lat, 7);
`else
    check_output("single_ready_seen", (lat < 30), 1'b1);
`endif
    repeat (4) @(negedge clk);
    check_output("single_writes", n_writes - s_w, 1);
    w_idx = -1;
    for (int i = s_tr; i < tr_log.size(); i++) if (tr_log[i].we && w_idx < 0) w_idx = i;
    if (w_idx <= s_tr) check_output("single_write_found", 1'b0, 1'b1);
    else begin
      check_output("single_write_txn", tr_log[w_idx], {1'b1, 4'b1000, 32'h4100_0000});
      check_output("single_poll_txn", {tr_log[w_idx-1].we, tr_log[w_idx-1].sel}, 5'b0_0100);
    end
`ifndef UART_SCHED_RX_EN
    check_output("single_txn_count", tr_log.size() - s_tr, 2);
    check_output("single_idle_busy", busy, 1'b0);
`endif

    $display("[TB] round robin");
    do_reset();
    s_r = n_ready; s_wl = wr_log.size();
    @(posedge clk); #1;
    apply_stimulus(0, 8'h10, 2); apply_stimulus(1, 8'h11, 1);
    apply_stimulus(2, 8'h12, 1); apply_stimulus(3, 8'h13, 1);
    wait_readies(s_r + 5, "rr_done");
    check_output("rr_ready_count", n_ready - s_r, 5);
    for (int i = 0; i < 5; i++)
      if (s_wl + i < wr_log.size()) check_output("rr_order", wr_log[s_wl + i], rr_exp[i]);
      else check_output("rr_order_missing", 1'b0, 1'b1);

    $display("[TB] tx busy");
    do_reset();
    s_w = n_writes; s_r = n_ready; s_p = n_polls;
    busy_polls = 3;
    @(posedge clk); #1 apply_stimulus(2, 8'hA5, 1);
    wait_readies(s_r + 1, "busy_done");
    repeat (10) @(negedge clk);
    check_output("busy_writes", n_writes - s_w, 1);
    check_output("busy_readies", n_ready - s_r, 1);
    check_output("busy_last_byte", wr_log[wr_log.size()-1], 8'hA5);
`ifndef UART_SCHED_RX_EN
    check_output("busy_polls", n_polls - s_p, 4);
`endif

    $display("[TB] requester drops before write");
    do_reset();
    s_w = n_writes; s_r = n_ready;
    @(posedge clk); #1 apply_stimulus(2, 8'h99, 1);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(wb_stb_o && wb_ack_i && !wb_we_o) && k < 50);
    check_output("drop_poll_seen", (k < 50), 1'b1);
    @(negedge clk);
    vld[2] = 1'b0;
    repeat (12) @(negedge clk);
    check_output("drop_writes", n_writes - s_w, 0);
    check_output("drop_readies", n_ready - s_r, 0);
    @(posedge clk); #1 apply_stimulus(2, 8'h9A, 1);
    wait_readies(s_r + 1, "drop_resend_done");
    check_output("drop_resend_byte", wr_log[wr_log.size()-1], 8'h9A);

    $display("[TB] extra ack");
    do_reset();
    s_w = n_writes; s_r = n_ready; s_p = n_polls;
    extra_ack = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(0, 8'hC0, 1); apply_stimulus(3, 8'hC3, 1);
    wait_readies(s_r + 2, "extra_done");
    repeat (10) @(negedge clk);
    check_output("extra_writes", n_writes - s_w, 2);
    check_output("extra_readies", n_ready - s_r, 2);
    check_output("extra_bytes", {wr_log[wr_log.size()-2], wr_log[wr_log.size()-1]}, 16'hC0C3);
`ifndef UART_SCHED_RX_EN
    check_output("extra_polls", n_polls - s_p, 2);
`endif
    extra_ack = 1'b0;

    $display("[TB] reset mid-write");
    do_reset();
    s_w = n_writes; s_r = n_ready;
    @(posedge clk); #1 apply_stimulus(0, 8'h77, 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!(wb_stb_o && wb_we_o) && k < 50);
    check_output("midreset_write_seen", (k < 50), 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midreset_bus_dropped", {wb_cyc_o, wb_stb_o, req_ready}, 6'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_readies(s_r + 1, "midreset_done");
    repeat (10) @(negedge clk);
    check_output("midreset_writes", n_writes - s_w, 1);
    check_output("midreset_readies", n_ready - s_r, 1);
    check_output("midreset_byte", wr_log[wr_log.size()-1], 8'h77);

`ifdef UART_SCHED_RX_EN
    $display("[TB] rx before tx");
    do_reset();
    s_r = n_ready; s_p = n_rxv; s_tr = tr_log.size();
    rx_byte_m = 8'h5A;
    @(posedge clk); #1 rx_full_m = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(wb_stb_o && wb_ack_i && !wb_we_o && wb_sel_o == 4'b0100 && wb_dat_i[16]) && k < 50);
    check_output("rx_full_poll_seen", (k < 50), 1'b1);
    apply_stimulus(1, 8'h21, 1);
    wait_readies(s_r + 1, "rx_tx_done");
    rx_idx = -1; w_idx = -1;
    for (int i = s_tr; i < tr_log.size(); i++) begin
      if (!tr_log[i].we && tr_log[i].sel == 4'b1000 && rx_idx < 0) rx_idx = i;
      if (tr_log[i].we && w_idx < 0) w_idx = i;
    end
    check_output("rx_before_tx", (rx_idx >= 0 && w_idx > rx_idx), 1'b1);
    check_output("rx_data_kept", rx_data, 8'h5A);
    check_output("rx_valid_count", n_rxv - s_p, 1);
    check_output("rx_tx_byte", wr_log[wr_log.size()-1], 8'h21);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_sched.md
# uart_sched

Wishbone master that shares the lab UART transmitter among `N_REQ` byte requesters and, optionally, drains the UART receiver. It polls the UART status byte, grants one requester at a time in round-robin order, and writes the granted byte to the UART data lane. It sits between on-chip byte producers and the UART wishbone slave, replacing direct software polling.

## Interface
Parameters:
- `N_REQ`, 4: number of TX requesters; legal range 2..8.
- `UART_BASE`, 32'h9000_0000: UART register word address. Bit 2 is always 0.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `req_valid`  in  N_REQ  requester i has a byte pending; held high until `req_ready[i]`.
- `req_data`  in  8*N_REQ  byte of requester i in bits [8i+7:8i]; stable while valid.
- `req_ready`  out  N_REQ  one-cycle pulse: requester i's byte was written to the UART.
- `rx_data`  out  8  last received byte (RX feature only; otherwise 0).
- `rx_valid`  out  1  one-cycle pulse with new `rx_data` (RX feature only; otherwise 0).
- `busy`  out  1  FSM not in IDLE.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  wishbone master control.
- `wb_adr_o`  out  32  always `UART_BASE`.
- `wb_sel_o`  out  4  byte lanes.
- `wb_dat_o`  out  32  write data.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`  in  1  slave acknowledge.

## Operation
- UART status word layout: [31:24] RX byte, [22:21] tx_empty (2'b11 = empty), [16] rx_full.
- Status poll: read, `sel`=4'b0100. It must not touch lane 3, because a lane-3 read clears rx_full.
- RX read: read, `sel`=4'b1000. It captures [31:24] and clears rx_full in the slave.
- TX write: write, `sel`=4'b1000, `dat_o`={byte, 24'h0}.
- FSM states:
  - IDLE: leave for POLL when any `req_valid` is high. With RX enabled, always leave for POLL.
  - POLL: latch the grant index (the first valid requester at or after `rr_ptr`). On `ack`, latch tx_empty and rx_full, then go to GAP1.
  - GAP1: one cycle with cyc/stb low. Then go to RXRD if RX is enabled and rx_full=1. Else go to WRITE if tx_empty==2'b11 and the granted requester is still valid. Else go to IDLE.
  - RXRD: on `ack`, set `rx_data`=dat_i[31:24], pulse `rx_valid`, go to GAP2.
  - WRITE: latch `req_data` of the grant on entry. On `ack`, pulse `req_ready[grant]`, set `rr_ptr`=grant+1 mod N_REQ, go to GAP2.
  - GAP2: one cycle with cyc/stb low, then go to IDLE.
- Priority:
  - RX read takes precedence over TX write after a poll, so RX does not overrun.
  - After an RX read, TX is re-evaluated by a fresh poll.
- Round robin:
  - `rr_ptr` resets to 0.
  - A requester that drops valid before WRITE loses its slot without a `req_ready` pulse.
  - A requester never receives two consecutive grants while another requester is valid.
- `ack_i` is ignored whenever `stb_o` is low. The slave returns ack one cycle after stb, and may return one more.

## Timing
- Reset values: all wishbone outputs 0, `req_ready`=0, `rx_valid`=0, `rx_data`=0, `busy`=0, state IDLE, `rr_ptr`=0.
- A reset mid-cycle drops cyc/stb on the next edge. No `req_ready` is issued for an interrupted write.
- cyc and stb are asserted together and deasserted on the edge after `ack_i` is sampled high.
- With the UART ack latency of 1, the sequence is:
  - POLL 2 cycles, GAP1 1 cycle, WRITE 2 cycles, GAP2 1 cycle, IDLE 1 cycle.
  - One byte therefore takes 7 cycles, from `req_valid` rising to the `req_ready` pulse.
- Back-to-back bytes are throttled by tx_empty. A poll that shows tx_empty != 2'b11 returns to IDLE, and re-polling starts immediately.
- `req_ready` and `rx_valid` are registered outputs, high for exactly one cycle.

## Configuration
- `UART_SCHED_RX_EN` defined:
  - RXRD state present; IDLE polls continuously.
  - `rx_data`/`rx_valid` are driven as described.
- Not defined:
  - RXRD is removed; IDLE polls only while a request is pending.
  - rx_full is ignored; `rx_data` and `rx_valid` are tied to 0.
  - Lane 3 is never read.

## Test plan
- Single byte: reset, then requester 0 sends 8'h41 with a UART model reporting tx_empty=11 → one status read (sel 0100), then one write (sel 1000, dat 32'h4100_0000), then `req_ready[0]` 7 cycles after valid.
- Round robin: all 4 requesters valid, holding 8'h10..8'h13 → bytes written in order 10,11,12,13, then 10 again. Each `req_ready` pulse goes only to the owner.
- TX busy: the model reports tx_empty=00 for 3 polls, then 11 → no write during the busy polls, exactly one write after, no lost or duplicate `req_ready`.
- RX (macro on): the model asserts rx_full with byte 8'h5A while requester 1 is pending → RX read (sel 1000, we 0) comes before the TX write, `rx_data`=8'h5A with a one-cycle `rx_valid`, then the TX byte is written.
- Reset mid-write: `rst_n` low during WRITE with stb high → cyc/stb are 0 on the next edge, there is no `req_ready`, and after reset the same byte is re-sent from requester 0.
- Extra ack: the slave holds ack one cycle after stb drops → the FSM ignores it, with no duplicate write or state skip.
